memory_access_unit: RTL and testbench

// - MA stage between execute_unit and write-back; owns the data-memory request/ack port.
// - Registers EX results; issues word loads/stores and stalls the pipeline until ack.
// - Selects WB data (ALU / load / PC+4) and supplies the MA forward value to EX.

---
 rtl/memory_access_unit_if.sv | 19 +
 rtl/memory_access_unit.sv | 169 ++++++++++++++++
 tb/tb_memory_access_unit.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/memory_access_unit_if.sv
// Shared pipeline sizes and the data-memory request/ack port used by the MA stage.
// master = memory_access_unit side, slave = data memory side.
package multicore_pkg;
  localparam int DATA_SIZE = 32;
  localparam int INST_SIZE = 32;
  localparam int NUM_REGS  = 32;
endpackage

interface memory_access_unit_if;
  logic                                 req;
  logic                                 we;
  logic [multicore_pkg::DATA_SIZE-1:0]  addr;
  logic [multicore_pkg::DATA_SIZE-1:0]  wdata;
  logic                                 ack;
  logic [multicore_pkg::DATA_SIZE-1:0]  rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/memory_access_unit.sv
// MA pipeline stage: registers EX results, runs the word load/store handshake and selects
// the write-back value. Define MA_BUS_TIMEOUT_EN to abort accesses that never get an ack.
module memory_access_unit
  import multicore_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd256
) (
  input  logic                        i_aclk,
  input  logic                        i_areset_n,
  input  logic                        i_en,
  input  logic [DATA_SIZE-1:0]        i_exe_calc,
  input  logic [DATA_SIZE-1:0]        i_exe_wdata,
  input  logic [INST_SIZE-1:0]        i_pcplus4,
  input  logic [$clog2(NUM_REGS)-1:0] i_rdest,
  input  logic                        i_cu_regwrite,
  input  logic [1:0]                  i_cu_memtoreg,
  input  logic                        i_cu_memwrite,
  memory_access_unit_if.master        dmem,
  output logic                        o_stall,
  output logic [DATA_SIZE-1:0]        o_forward_data,
  output logic [DATA_SIZE-1:0]        o_wb_data,
  output logic [$clog2(NUM_REGS)-1:0] o_rdest,
  output logic                        o_cu_regwrite,
  output logic                        o_misaligned,
  output logic                        o_bus_err
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t                      state_r;
  logic [DATA_SIZE-1:0]        calc_r;
  logic [INST_SIZE-1:0]        pcplus4_r;
  logic [$clog2(NUM_REGS)-1:0] rdest_r;
  logic                        regwrite_r;
  logic                        memwrite_r;
  logic [1:0]                  memtoreg_r;
  logic [DATA_SIZE-1:0]        load_data_r;
  logic                        aborted_r;
  logic                        req_r;
  logic                        we_r;
  logic [DATA_SIZE-1:0]        bus_addr_r;
  logic [DATA_SIZE-1:0]        bus_wdata_r;
  logic                        start_s;
  logic                        misalign_s;
  logic [DATA_SIZE-1:0]        wb_data_s;

`ifdef MA_BUS_TIMEOUT_EN
  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
  logic [CNT_W-1:0]            cnt_r;
`endif

  // An incoming aligned load/store opens an access on the edge it enters the stage.
  assign start_s    = i_en & (i_cu_memwrite | (i_cu_memtoreg == 2'b01)) &
                      (i_exe_calc[1:0] == 2'b00);
  assign misalign_s = (memwrite_r | (memtoreg_r == 2'b01)) & (calc_r[1:0] != 2'b00);

  // Stage registers, access FSM and registered bus request.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_r     <= ST_IDLE;
      calc_r      <= {DATA_SIZE{1'b0}};
      pcplus4_r   <= {INST_SIZE{1'b0}};
      rdest_r     <= '0;
      regwrite_r  <= 1'b0;
      memwrite_r  <= 1'b0;
      memtoreg_r  <= 2'b00;
      load_data_r <= {DATA_SIZE{1'b0}};
      aborted_r   <= 1'b0;
      req_r       <= 1'b0;
      we_r        <= 1'b0;
      bus_addr_r  <= {DATA_SIZE{1'b0}};
      bus_wdata_r <= {DATA_SIZE{1'b0}};
`ifdef MA_BUS_TIMEOUT_EN
      cnt_r       <= '0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          calc_r     <= i_exe_calc;
          pcplus4_r  <= i_pcplus4;
          rdest_r    <= i_rdest;
          regwrite_r <= i_en & i_cu_regwrite;
          memwrite_r <= i_en & i_cu_memwrite;
          memtoreg_r <= i_en ? i_cu_memtoreg : 2'b00;
          aborted_r  <= 1'b0;
          if (start_s) begin
            state_r     <= ST_ACCESS;
            req_r       <= 1'b1;
            we_r        <= i_cu_memwrite;
            bus_addr_r  <= {i_exe_calc[DATA_SIZE-1:2], 2'b00};
            bus_wdata_r <= i_exe_wdata;
`ifdef MA_BUS_TIMEOUT_EN
            cnt_r       <= '0;
`endif
          end else begin
            state_r     <= ST_IDLE;
            req_r       <= 1'b0;
            we_r        <= 1'b0;
            bus_addr_r  <= {DATA_SIZE{1'b0}};
            bus_wdata_r <= {DATA_SIZE{1'b0}};
          end
        end
        ST_ACCESS: begin
          // Ack is checked first so an ack on the last allowed cycle still completes.
          if (dmem.ack) begin
            load_data_r <= dmem.rdata;
            state_r     <= ST_IDLE;
            req_r       <= 1'b0;
            we_r        <= 1'b0;
            bus_addr_r  <= {DATA_SIZE{1'b0}};
            bus_wdata_r <= {DATA_SIZE{1'b0}};
          end
`ifdef MA_BUS_TIMEOUT_EN
          else if (cnt_r == CNT_LAST) begin
            aborted_r   <= 1'b1;
            state_r     <= ST_IDLE;
            req_r       <= 1'b0;
            we_r        <= 1'b0;
            bus_addr_r  <= {DATA_SIZE{1'b0}};
            bus_wdata_r <= {DATA_SIZE{1'b0}};
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
`else
          else begin
            state_r <= ST_ACCESS;
          end
`endif
        end
        default: begin
          state_r <= ST_IDLE;
          req_r   <= 1'b0;
          we_r    <= 1'b0;
        end
      endcase
    end
  end

  // Write-back source select; the reserved encoding falls back to the ALU result.
  always_comb begin
    wb_data_s = calc_r;
    case (memtoreg_r)
      2'b01:   wb_data_s = load_data_r;
      2'b10:   wb_data_s = DATA_SIZE'(pcplus4_r);
      default: wb_data_s = calc_r;
    endcase
  end

  assign dmem.req       = req_r;
  assign dmem.we        = we_r;
  assign dmem.addr      = bus_addr_r;
  assign dmem.wdata     = bus_wdata_r;
  assign o_stall        = (state_r == ST_ACCESS);
  assign o_forward_data = calc_r;
  assign o_wb_data      = wb_data_s;
  assign o_rdest        = rdest_r;
  assign o_cu_regwrite  = regwrite_r & ~o_stall & ~misalign_s & ~aborted_r;
  assign o_misaligned   = misalign_s;
`ifdef MA_BUS_TIMEOUT_EN
  assign o_bus_err      = aborted_r;
`else
  assign o_bus_err      = 1'b0;
`endif

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed plus randomized bench for memory_access_unit with a transaction-level model
// and a behavioural data-memory slave.
module tb_memory_access_unit;
  import multicore_pkg::*;

  localparam int RW = $clog2(NUM_REGS);
`ifdef MA_BUS_TIMEOUT_EN
  localparam int MAX_DLY = 3;
`else
  localparam int MAX_DLY = 5;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 en;
  logic [DATA_SIZE-1:0] calc;
  logic [DATA_SIZE-1:0] wdata;
  logic [INST_SIZE-1:0] pc4;
  logic [RW-1:0]        rd;
  logic                 rw;
  logic [1:0]           m2r;
  logic                 mw;
  logic                 stall;
  logic [DATA_SIZE-1:0] fwd;
  logic [DATA_SIZE-1:0] wb;
  logic [RW-1:0]        rdest_o;
  logic                 rw_o;
  logic                 mis_o;
  logic                 berr_o;

  memory_access_unit_if dmem_if();

  memory_access_unit #(.TIMEOUT_CYCLES(32'd4)) dut (
    .i_aclk         (clk),
    .i_areset_n     (rst_n),
    .i_en           (en),
    .i_exe_calc     (calc),
    .i_exe_wdata    (wdata),
    .i_pcplus4      (pc4),
    .i_rdest        (rd),
    .i_cu_regwrite  (rw),
    .i_cu_memtoreg  (m2r),
    .i_cu_memwrite  (mw),
    .dmem           (dmem_if),
    .o_stall        (stall),
    .o_forward_data (fwd),
    .o_wb_data      (wb),
    .o_rdest        (rdest_o),
    .o_cu_regwrite  (rw_o),
    .o_misaligned   (mis_o),
    .o_bus_err      (berr_o)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] ref_mem   [logic [31:0]];
  logic [31:0] slave_mem [logic [31:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one instruction into MA and checks it through to its write-back cycle.
  // Entered and left #1 after a rising edge.
  task automatic apply(input logic a_en, input logic [31:0] a_calc, input logic [31:0] a_wdata,
                       input logic [31:0] a_pc4, input logic [RW-1:0] a_rd, input logic a_rw,
                       input logic [1:0] a_m2r, input logic a_mw, input int a_delay);
    logic        memop, mis, acc, exp_rw;
    logic [31:0] word, exp_wb;
    memop  = a_mw | (a_m2r == 2'b01);
    mis    = a_en & memop & (a_calc[1:0] != 2'b00);
    acc    = a_en & memop & ~mis;
    exp_rw = a_en & a_rw & ~mis;
    word   = {a_calc[31:2], 2'b00};
    if (a_m2r == 2'b01)      exp_wb = ref_mem.exists(word) ? ref_mem[word] : 32'h0;
    else if (a_m2r == 2'b10) exp_wb = a_pc4;
    else                     exp_wb = a_calc;

    en = a_en; calc = a_calc; wdata = a_wdata; pc4 = a_pc4;
    rd = a_rd; rw = a_rw; m2r = a_m2r; mw = a_mw;
    @(posedge clk); #1;
    dmem_if.ack = 1'b0;

    if (acc) begin
      for (int k = 0; k <= a_delay; k++) begin
        chk("acc_req",   32'(dmem_if.req), 32'(1'b1));
        chk("acc_stall", 32'(stall), 32'(1'b1));
        chk("acc_addr",  dmem_if.addr, word);
        chk("acc_we",    32'(dmem_if.we), 32'(a_mw));
        if (a_mw) chk("acc_wdata", dmem_if.wdata, a_wdata);
        chk("acc_wb_en", 32'(rw_o), 32'(1'b0));
        chk("acc_mis",   32'(mis_o), 32'(1'b0));
        // Garbage on the EX side must not disturb a frozen stage.
        en = 1'($urandom); calc = $urandom; wdata = $urandom; pc4 = $urandom;
        rd = RW'($urandom); rw = 1'($urandom); m2r = 2'($urandom); mw = 1'($urandom);
        if (k == a_delay) begin
          if (dmem_if.we) slave_mem[dmem_if.addr] = dmem_if.wdata;
          dmem_if.rdata = slave_mem.exists(dmem_if.addr) ? slave_mem[dmem_if.addr] : 32'h0;
          dmem_if.ack   = 1'b1;
        end
        @(posedge clk); #1;
        dmem_if.ack   = 1'b0;
        dmem_if.rdata = $urandom;
      end
      if (a_mw) ref_mem[word] = a_wdata;
    end

    chk("wb_stall", 32'(stall), 32'(1'b0));
    chk("wb_req",   32'(dmem_if.req), 32'(1'b0));
    chk("wb_mis",   32'(mis_o), 32'(mis));
    chk("wb_en",    32'(rw_o), 32'(exp_rw));
    chk("wb_fwd",   fwd, a_calc);
    chk("wb_berr",  32'(berr_o), 32'(1'b0));
    if (exp_rw) begin
      chk("wb_data",  wb, exp_wb);
      chk("wb_rdest", 32'(rdest_o), 32'(a_rd));
    end
    // Occasionally raise a stray ack while no request is pending.
    if (!acc && ($urandom_range(0, 3) == 0)) begin
      dmem_if.ack   = 1'b1;
      dmem_if.rdata = $urandom;
    end
  endtask

  int          kind;
  logic [31:0] c;
  logic [31:0] v;

  initial begin
    rst_n = 1'b0; en = 1'b0; calc = 32'h0; wdata = 32'h0; pc4 = 32'h0;
    rd = '0; rw = 1'b0; m2r = 2'b00; mw = 1'b0;
    dmem_if.ack = 1'b0; dmem_if.rdata = 32'h0;
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      ref_mem[32'h100 + 32'(i * 4)]   = v;
      slave_mem[32'h100 + 32'(i * 4)] = v;
    end

    #2;
    chk("rst_req",   32'(dmem_if.req), 32'h0);
    chk("rst_we",    32'(dmem_if.we), 32'h0);
    chk("rst_addr",  dmem_if.addr, 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_wb_en", 32'(rw_o), 32'h0);
    chk("rst_wb",    wb, 32'h0);
    chk("rst_fwd",   fwd, 32'h0);
    chk("rst_rdest", 32'(rdest_o), 32'h0);
    chk("rst_mis",   32'(mis_o), 32'h0);
    chk("rst_berr",  32'(berr_o), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    apply(1'b1, 32'h10, 32'h0, 32'h0, RW'(5), 1'b1, 2'b00, 1'b0, 0);
    ref_mem[32'h100] = 32'hDEADBEEF; slave_mem[32'h100] = 32'hDEADBEEF;
    apply(1'b1, 32'h100, 32'h0, 32'h0, RW'(7), 1'b1, 2'b01, 1'b0, 2);
    apply(1'b1, 32'h204, 32'h55, 32'h0, RW'(0), 1'b0, 2'b00, 1'b1, 0);
    apply(1'b1, 32'h102, 32'h0, 32'h0, RW'(3), 1'b1, 2'b01, 1'b0, 0);
    apply(1'b1, 32'h999, 32'h0, 32'h48, RW'(1), 1'b1, 2'b10, 1'b0, 0);
    apply(1'b0, 32'h77, 32'h0, 32'h48, RW'(1), 1'b1, 2'b10, 1'b0, 0);
    apply(1'b1, 32'h208, 32'h0, 32'h0, RW'(9), 1'b1, 2'b01, 1'b0, 0);

    // Reset pulled while an access is outstanding.
    en = 1'b1; calc = 32'h108; m2r = 2'b01; rw = 1'b1; mw = 1'b0; dmem_if.ack = 1'b0;
    @(posedge clk); #1;
    chk("mid_req_up", 32'(dmem_if.req), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req",   32'(dmem_if.req), 32'h0);
    chk("mid_rst_stall", 32'(stall), 32'h0);
    chk("mid_rst_wb_en", 32'(rw_o), 32'h0);
    chk("mid_rst_fwd",   fwd, 32'h0);
    en = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_req",   32'(dmem_if.req), 32'h0);
    chk("post_rst_stall", 32'(stall), 32'h0);

`ifdef MA_BUS_TIMEOUT_EN
    // No ack at all: four ACCESS cycles, then an abort with no write-back.
    en = 1'b1; calc = 32'h10C; m2r = 2'b01; rw = 1'b1; mw = 1'b0;
    @(posedge clk); #1;
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("to_req",  32'(dmem_if.req), 32'h1);
      chk("to_berr", 32'(berr_o), 32'h0);
      @(posedge clk); #1;
    end
    chk("to_req_drop", 32'(dmem_if.req), 32'h0);
    chk("to_stall",    32'(stall), 32'h0);
    chk("to_berr_hi",  32'(berr_o), 32'h1);
    chk("to_wb_en",    32'(rw_o), 32'h0);
    @(posedge clk); #1;
    chk("to_berr_lo",  32'(berr_o), 32'h0);
    apply(1'b1, 32'h110, 32'h0, 32'h0, RW'(4), 1'b1, 2'b01, 1'b0, 3);
`endif

    // Randomized instruction stream.
    for (int n = 0; n < 250; n++) begin
      kind = $urandom_range(0, 4);
      c = 32'h100 + {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 5) == 0) c[1:0] = 2'($urandom_range(1, 3));
      case (kind)
        0: apply(1'b1, $urandom, $urandom, $urandom, RW'($urandom), 1'($urandom),
                 ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11, 1'b0, 0);
        1: apply(1'b1, c, $urandom, $urandom, RW'($urandom), 1'b1, 2'b01, 1'b0,
                 $urandom_range(0, MAX_DLY));
        2: apply(1'b1, c, $urandom, $urandom, RW'($urandom), 1'b0, 2'b00, 1'b1,
                 $urandom_range(0, MAX_DLY));
        3: apply(1'b1, $urandom, $urandom, $urandom, RW'($urandom), 1'b1, 2'b10, 1'b0, 0);
        default: apply(1'b0, c, $urandom, $urandom, RW'($urandom), 1'b1, 2'($urandom),
                       1'($urandom), 0);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
